// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the instruction fetch path.
//   FETCH_FIFO_DEPTH    - number of fetched words decode may leave buffered.
//   DEFAULT_DATA_WIDTH  - default instruction width (matches imem data).
//   DEFAULT_ADDR_WIDTH  - default word-address width (matches imem address).
//   fetch_entry_t       - one buffered {instr, pc} pair at the default widths.
package cpu_fetch_pkg;

  localparam int FETCH_FIFO_DEPTH   = 2;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 10;

  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] instr;
    logic [DEFAULT_ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO holding fetched {instr, pc} pairs.
// Ports:
//   clk, rst             - clock; asynchronous active-high reset (empties FIFO).
//   push, push_instr/pc  - write one entry at posedge.
//   pop                  - drop the head entry at posedge.
//   flush                - empty the FIFO; wins over push and pop.
//   count                - current occupancy, 0..FETCH_FIFO_DEPTH.
//   head_instr, head_pc  - head entry; forced to 0 when empty.
module fetch_fifo
  import cpu_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_instr,
  input  logic [ADDR_WIDTH-1:0] push_pc,
  input  logic                  pop,
  input  logic                  flush,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head_instr,
  output logic [ADDR_WIDTH-1:0] head_pc
);

  localparam logic [1:0] DEPTH = 2'(FETCH_FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_instr [FETCH_FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_pc    [FETCH_FIFO_DEPTH];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Guards keep the pointers consistent even if a caller misbehaves.
  assign do_push = push & (count != DEPTH);
  assign do_pop  = pop & (count != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage needs no reset: the head is gated by count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_instr[wr_ptr] <= push_instr;
      mem_pc[wr_ptr]    <= push_pc;
    end
  end

  assign head_instr = (count != 2'd0) ? mem_instr[rd_ptr] : '0;
  assign head_pc    = (count != 2'd0) ? mem_pc[rd_ptr]    : '0;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: owns the PC, drives the synchronous instruction
// memory, absorbs its one-cycle read latency and hands {instr, pc} pairs to
// decode.
// Ports:
//   clk, rst                     - clock; asynchronous active-high reset.
//   imem_address                 - word address to imem (straight from fetch_pc).
//   imem_data                    - imem word for the address sampled last posedge.
//   redirect_valid, redirect_pc  - taken branch/jump and its word target.
//   instr_valid, instr_ready     - decode handshake.
//   instr, instr_pc              - fetched word and its word address.
//
// Handshake: a word transfers at a posedge where instr_valid & instr_ready
// are both high. instr_valid never depends on instr_ready, and instr/instr_pc
// stay stable while instr_valid is high and instr_ready is low. A transfer in
// a redirect cycle still completes even though the FIFO is flushed.
module instruction_fetch
  import cpu_fetch_pkg::*;
#(
  parameter int                  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int                  ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_address,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc
);

  localparam logic [1:0] DEPTH = 2'(FETCH_FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  inflight_valid;
  logic [1:0]            occ;
  logic [1:0]            slots_used;
  logic                  pop;
  logic                  issue;

  assign pop = instr_valid & instr_ready;

  // Slots claimed after this edge: buffered + arriving - leaving. Issue only
  // when a slot is free for the word that would land one cycle later.
  // occ + inflight never exceeds 3, so two bits suffice.
  assign slots_used = occ + {1'b0, inflight_valid} - {1'b0, pop};
  assign issue      = slots_used < DEPTH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc       <= RESET_PC;
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
    end else if (redirect_valid) begin
      fetch_pc       <= redirect_pc;
      inflight_valid <= 1'b0;
    end else if (issue) begin
      inflight_valid <= 1'b1;
      inflight_pc    <= fetch_pc;
      fetch_pc       <= fetch_pc + 1'b1;
    end else begin
      inflight_valid <= 1'b0;
    end
  end

  assign imem_address = fetch_pc;

  fetch_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight_valid),
    .push_instr (imem_data),
    .push_pc    (inflight_pc),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (occ),
    .head_instr (instr),
    .head_pc    (instr_pc)
  );

  assign instr_valid = (occ != 2'd0);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a per-cycle vector table covering
// startup, back-pressure, redirects (incl. pop in redirect cycle) and PC wrap,
// plus hand-written asynchronous reset sequences.
module tb_instruction_fetch;

  localparam int DW = 32;
  localparam int AW = 10;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] imem_address;
  logic [DW-1:0] imem_data = '0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;

  instruction_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC('0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_address   (imem_address),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  // memory model: 1-cycle synchronous ROM
  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    if (a == 10'd0) return 32'h16E00C00;
    if (a == 10'd1) return 32'h16E10C01;
    return DW'(a);
  endfunction

  always @(posedge clk) imem_data <= rom(imem_address);

  // scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic exp_v,
                               input logic [AW-1:0] exp_pc, input logic [AW-1:0] exp_addr);
    logic [DW-1:0] exp_instr;
    exp_instr = exp_v ? rom(exp_pc) : '0;
    check({tag, ".valid"}, DW'(instr_valid), DW'(exp_v));
    check({tag, ".pc"},    DW'(instr_pc),    exp_v ? DW'(exp_pc) : '0);
    check({tag, ".instr"}, instr,            exp_instr);
    check({tag, ".addr"},  DW'(imem_address), DW'(exp_addr));
  endtask

  typedef struct {
    logic          rv;
    logic [AW-1:0] rpc;
    logic          rdy;
    logic          exp_v;
    logic [AW-1:0] exp_pc;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rv, input int rpc, input logic rdy,
                              input logic v, input int pc, input int addr);
    vec_t r;
    r.rv = rv; r.rpc = AW'(rpc); r.rdy = rdy;
    r.exp_v = v; r.exp_pc = AW'(pc); r.exp_addr = AW'(addr);
    return r;
  endfunction

  initial begin
    // cycle-by-cycle vectors starting at the cycle rst is released
    vecs.push_back(mk(0, 0,    1, 0, 0,    0));    // before E1
    vecs.push_back(mk(0, 0,    1, 0, 0,    1));    // E1 issued pc0
    vecs.push_back(mk(0, 0,    1, 1, 0,    2));    // pc0 valid after E2
    vecs.push_back(mk(0, 0,    1, 1, 1,    3));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0,  0, 1, 2,    4));    // back-pressure, head frozen
    vecs.push_back(mk(0, 0,    1, 1, 2,    4));    // release
    vecs.push_back(mk(0, 0,    1, 1, 3,    5));
    vecs.push_back(mk(0, 0,    1, 1, 4,    6));
    vecs.push_back(mk(1, 8,    1, 1, 5,    7));    // pop pc5 + redirect to 8
    vecs.push_back(mk(0, 0,    1, 0, 0,    8));
    vecs.push_back(mk(0, 0,    1, 0, 0,    9));
    vecs.push_back(mk(0, 0,    1, 1, 8,    10));   // 6 and 7 never appear
    vecs.push_back(mk(0, 0,    0, 1, 9,    11));   // fill FIFO to 2
    vecs.push_back(mk(1, 14,   0, 1, 9,    11));   // redirect with full FIFO
    vecs.push_back(mk(0, 0,    1, 0, 0,    14));
    vecs.push_back(mk(0, 0,    1, 0, 0,    15));
    vecs.push_back(mk(0, 0,    1, 1, 14,   16));
    vecs.push_back(mk(0, 0,    1, 1, 15,   17));
    vecs.push_back(mk(1, 1022, 1, 1, 16,   18));   // redirect near top
    vecs.push_back(mk(0, 0,    1, 0, 0,    1022));
    vecs.push_back(mk(0, 0,    1, 0, 0,    1023));
    vecs.push_back(mk(0, 0,    1, 1, 1022, 0));    // fetch_pc wrapped
    vecs.push_back(mk(0, 0,    1, 1, 1023, 1));
    vecs.push_back(mk(0, 0,    1, 1, 0,    2));
    vecs.push_back(mk(0, 0,    1, 1, 1,    3));

    // reset state during power-up reset
    #1;
    check_outputs("reset", 1'b0, '0, '0);
    repeat (3) @(posedge clk);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      instr_ready    = vecs[i].rdy;
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_pc, vecs[i].exp_addr);
    end

    // asynchronous reset between edges while stream is running
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_outputs("async_rst", 1'b0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      case (i)
        0: check_outputs("restart0", 1'b0, '0, 10'd0);
        1: check_outputs("restart1", 1'b0, '0, 10'd1);
        2: check_outputs("restart2", 1'b1, 10'd0, 10'd2);
        default: check_outputs("restart3", 1'b1, 10'd1, 10'd3);
      endcase
    end

    // reset asserted with the FIFO full under back-pressure
    instr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_outputs("async_rst_full", 1'b0, '0, '0);
    @(negedge clk);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit: the reading side of the synchronous instruction memory in the MIPS CPU. It owns the program counter and drives the memory address. It absorbs the memory's fixed one-cycle read latency and delivers (instruction, pc) pairs to decode over a valid/ready handshake. Supports decode back-pressure and branch/jump redirects without losing or duplicating words.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction width; matches instruction memory data width.
- ADDR_WIDTH, 10, word-address width; matches instruction memory address width.
- RESET_PC, 0, word address fetched first after reset.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- imem_address  out  ADDR_WIDTH  word address to instruction memory; driven straight from a register.
- imem_data  in  DATA_WIDTH  memory read data; holds the word at the address sampled on the previous posedge.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  ADDR_WIDTH  word-address target; used only when redirect_valid=1.
- instr_valid  out  1  instr/instr_pc hold a fetched word.
- instr_ready  in  1  decode accepts; transfer when instr_valid & instr_ready at posedge.
- instr  out  DATA_WIDTH  fetched instruction.
- instr_pc  out  ADDR_WIDTH  word address of instr.

## Operation
- State: fetch_pc (drives imem_address), inflight_valid/inflight_pc (one word in memory latency), 2-entry FIFO of {instr, pc}.
- pop = instr_valid & instr_ready; occ = FIFO occupancy 0..2.
- Issue condition: occ + inflight_valid − pop < 2. On issue at a posedge:
  - inflight_valid <= 1, inflight_pc <= fetch_pc.
  - fetch_pc <= fetch_pc + 1, modulo 2^ADDR_WIDTH, so 1023 wraps to 0.
- No issue: inflight_valid <= 0 and fetch_pc holds. Memory still reads fetch_pc; the result is ignored.
- Posedge with inflight_valid=1: push {imem_data, inflight_pc} into the FIFO. The issue rule guarantees the FIFO is never full at push. Push and pop in the same cycle are both honoured.
- instr_valid = FIFO non-empty. instr/instr_pc = FIFO head. instr and instr_pc are 0 when the FIFO is empty.
- Redirect (redirect_valid=1 at posedge) takes priority over issue, push and pop:
  - fetch_pc <= redirect_pc.
  - inflight_valid <= 0.
  - FIFO cleared.
  - A pop in the redirect cycle still counts as a completed transfer for decode.
- No instruction decoding. Words pass through unchanged.

## Timing
- Reset values: fetch_pc = imem_address = RESET_PC; inflight_valid = 0; FIFO empty; instr_valid = 0; instr = 0; instr_pc = 0. Outputs take these values immediately on rst assertion, with no clock edge.
- Startup: first posedge with rst low = E1 (issues RESET_PC). Push at E2, so instr_valid is high in the cycle after E2.
- Redirect at edge R: target issued at R+1 and pushed at R+2. instr_valid is low between R and R+2; the target word is valid after R+2.
- Steady state with instr_ready=1: one instruction per cycle, consecutive pcs, no bubbles.
- Back-pressure: instr_ready low holds the FIFO head stable, at most 2 words buffered, fetch_pc frozen. No word is lost or duplicated.
- Reset mid-operation: all in-flight and buffered words are discarded. Fetch restarts at RESET_PC as from power-up.
- Combinational path instr_ready → issue enable only. imem_address has no combinational input path.

## Structure
- Shared package cpu_fetch_pkg: FETCH_FIFO_DEPTH = 2; default DATA_WIDTH/ADDR_WIDTH; fetch entry struct {instr, pc}.
- One sub-module: fetch_fifo, a 2-entry synchronous FIFO with push, pop, flush, count and asynchronous active-high reset. PC/issue/in-flight control stays in instruction_fetch.

## Test plan
Memory model: 1-cycle synchronous ROM, word0 = 0x16E00C00, word1 = 0x16E10C01, wordN = N elsewhere.
- Release rst, instr_ready=1 → instr_valid rises after E2; outputs (pc, instr) = (0, 0x16E00C00), (1, 0x16E10C01), then (2, 2), (3, 3), one per cycle.
- After pcs 0 and 1 accepted, hold instr_ready=0 for 5 cycles → head stays (2, 2), imem_address stays 4. Release → pcs 2, 3, 4, 5 on consecutive cycles, no gaps, no repeats.
- redirect_valid=1, redirect_pc=14 while FIFO holds 2 words and instr_ready=0 → instr_valid low the next cycle. First valid output is (14, 14) after R+2, then 15, 16.
- Redirect to 1022 with instr_ready=1 → pcs 1022, 1023, 0, 1 in sequence (wrap).
- Redirect to 8 in the same cycle as a pop of pc 5 → pc 5 counts as transferred. Next output is pc 8; pcs 6 and 7 never appear.
- Assert rst asynchronously mid-stream between edges → instr_valid = 0 and imem_address = 0 before the next posedge. After release, output restarts at pc 0.
